// File: rtl/gpu_pkg.sv
// ----------------------------------------------------------------------------
// gpu_pkg : encodings shared by the compute-core control blocks
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package gpu_pkg;

   typedef enum logic [2:0] {
      CORE_IDLE    = 3'd0,
      CORE_FETCH   = 3'd1,
      CORE_DECODE  = 3'd2,
      CORE_REQUEST = 3'd3,
      CORE_WAIT    = 3'd4,
      CORE_EXECUTE = 3'd5,
      CORE_UPDATE  = 3'd6,
      CORE_DONE    = 3'd7
   } core_state_t;

   localparam logic [1:0] LSU_IDLE       = 2'd0;
   localparam logic [1:0] LSU_REQUESTING = 2'd1;
   localparam logic [1:0] LSU_WAITING    = 2'd2;
   localparam logic [1:0] LSU_DONE       = 2'd3;

   localparam logic [2:0] FETCHER_FETCHED = 3'b010;

endpackage

`default_nettype wire

// File: rtl/divergent_scheduler_min_pc_select.sv
// ----------------------------------------------------------------------------
// min_pc_select : combinational argmin over per-lane PCs, returns every lane
//                 that ties at the minimum.  Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module min_pc_select #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic [W*N-1:0] i_pcs,
   input  logic [N-1:0]   i_valid,
   output logic [W-1:0]   o_min_pc,
   output logic [N-1:0]   o_eq_mask
);

   always_comb begin
      o_min_pc  = '1;
      o_eq_mask = '0;
      for (int i = 0; i < N; i++) begin
         if (i_valid[i] && (i_pcs[W*i +: W] < o_min_pc)) begin
            o_min_pc = i_pcs[W*i +: W];
         end
      end
      for (int i = 0; i < N; i++) begin
         o_eq_mask[i] = i_valid[i] && (i_pcs[W*i +: W] == o_min_pc);
      end
   end

endmodule

`default_nettype wire

// File: rtl/divergent_scheduler.sv
// ----------------------------------------------------------------------------
// divergent_scheduler : SIMT control-flow scheduler issuing the lowest live PC.
// Optional macro DIVERGENCE_STATS_EN adds divergence_count.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module divergent_scheduler
   import gpu_pkg::*;
#(
   parameter int THREADS_PER_BLOCK = 4,
   parameter int PC_BITS           = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
   input  logic [2:0]                           fetcher_state,
   input  logic                                 decoded_mem_read_enable,
   input  logic                                 decoded_mem_write_enable,
   input  logic                                 decoded_ret,
   input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
   input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
   output logic [2:0]                           core_state,
   output logic [PC_BITS-1:0]                   current_pc,
   output logic [THREADS_PER_BLOCK-1:0]         thread_mask,
   output logic                                 done
`ifdef DIVERGENCE_STATS_EN
   ,
   output logic [15:0]                          divergence_count
`endif
);

   localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
   localparam int T   = THREADS_PER_BLOCK;

   core_state_t          r_state;
   logic [PC_BITS-1:0]   r_current_pc;
   logic [T-1:0]         r_thread_mask;
   logic                 r_done;
   logic [PC_BITS*T-1:0] r_pcs;
   logic [T-1:0]         r_live;
   logic [T-1:0]         r_retired;
`ifdef DIVERGENCE_STATS_EN
   logic [15:0]          r_div_cnt;
`endif

   logic [TCW-1:0]       w_tc_sat;
   logic [T-1:0]         w_launch_mask;
   logic                 w_lsu_busy;
   logic                 w_mem_op;
   logic [T-1:0]         w_retired_nxt;
   logic [PC_BITS*T-1:0] w_pcs_nxt;
   logic [T-1:0]         w_avail;
   logic [PC_BITS-1:0]   w_min_pc;
   logic [T-1:0]         w_min_mask;

   assign w_tc_sat = (thread_count > TCW'(T)) ? TCW'(T) : thread_count;
   assign w_mem_op = decoded_mem_read_enable | decoded_mem_write_enable;

   always_comb begin
      w_launch_mask = '0;
      w_lsu_busy    = 1'b0;
      for (int i = 0; i < T; i++) begin
         w_launch_mask[i] = (TCW'(i) < w_tc_sat);
         if (r_thread_mask[i] && ((lsu_state[2*i +: 2] == LSU_REQUESTING) ||
                                  (lsu_state[2*i +: 2] == LSU_WAITING))) begin
            w_lsu_busy = 1'b1;
         end
      end
   end

   // Post-UPDATE view of the lanes, used to pick the next issue group.
   always_comb begin
      w_retired_nxt = decoded_ret ? (r_retired | r_thread_mask) : r_retired;
      w_pcs_nxt     = r_pcs;
      for (int i = 0; i < T; i++) begin
         if (!decoded_ret && r_thread_mask[i]) begin
            w_pcs_nxt[PC_BITS*i +: PC_BITS] = next_pc[PC_BITS*i +: PC_BITS];
         end
      end
   end

   assign w_avail = r_live & ~w_retired_nxt;

   min_pc_select #(
      .N (T),
      .W (PC_BITS)
   ) u_min_pc (
      .i_pcs     (w_pcs_nxt),
      .i_valid   (w_avail),
      .o_min_pc  (w_min_pc),
      .o_eq_mask (w_min_mask)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= CORE_IDLE;
         r_current_pc  <= '0;
         r_thread_mask <= '0;
         r_done        <= 1'b0;
         r_pcs         <= '0;
         r_live        <= '0;
         r_retired     <= '0;
`ifdef DIVERGENCE_STATS_EN
         r_div_cnt     <= '0;
`endif
      end else begin
         case (r_state)
            CORE_IDLE: begin
               if (start) begin
`ifdef DIVERGENCE_STATS_EN
                  r_div_cnt <= '0;
`endif
                  if (w_tc_sat == '0) begin
                     r_state <= CORE_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_live        <= w_launch_mask;
                     r_thread_mask <= w_launch_mask;
                     r_retired     <= '0;
                     r_pcs         <= '0;
                     r_current_pc  <= '0;
                     r_state       <= CORE_FETCH;
                  end
               end
            end
            CORE_FETCH: begin
               if (fetcher_state == FETCHER_FETCHED) r_state <= CORE_DECODE;
            end
            CORE_DECODE:  r_state <= CORE_REQUEST;
            CORE_REQUEST: r_state <= CORE_WAIT;
            CORE_WAIT: begin
               // Memory status is only meaningful for LDR/STR.
               if (!(w_mem_op && w_lsu_busy)) r_state <= CORE_EXECUTE;
            end
            CORE_EXECUTE: r_state <= CORE_UPDATE;
            CORE_UPDATE: begin
               r_retired <= w_retired_nxt;
               r_pcs     <= w_pcs_nxt;
               if (w_avail == '0) begin
                  r_thread_mask <= '0;
                  r_done        <= 1'b1;
                  r_state       <= CORE_DONE;
               end else begin
                  r_current_pc  <= w_min_pc;
                  r_thread_mask <= w_min_mask;
                  r_state       <= CORE_FETCH;
`ifdef DIVERGENCE_STATS_EN
                  if ((w_min_mask != w_avail) && (r_div_cnt != 16'hFFFF)) begin
                     r_div_cnt <= r_div_cnt + 16'd1;
                  end
`endif
               end
            end
            CORE_DONE: r_state <= CORE_DONE;
            default:   r_state <= CORE_IDLE;
         endcase
      end
   end

   assign core_state  = r_state;
   assign current_pc  = r_current_pc;
   assign thread_mask = r_thread_mask;
   assign done        = r_done;
`ifdef DIVERGENCE_STATS_EN
   assign divergence_count = r_div_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_divergent_scheduler.sv
// ----------------------------------------------------------------------------
// tb_divergent_scheduler : program-driven environment with a lane-level model
// of issue order; a monitor checks each issued group and stage timing.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_divergent_scheduler;
   import gpu_pkg::*;

   localparam int T   = 4;
   localparam int PCB = 8;
   localparam int TCW = $clog2(T) + 1;
   localparam int NPC = 64;

   localparam int OP_ALU = 0;
   localparam int OP_LDR = 1;
   localparam int OP_STR = 2;
   localparam int OP_RET = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [TCW-1:0]   thread_count;
   logic [2:0]       fetcher_state;
   logic             rd_en, wr_en, ret_en;
   logic [2*T-1:0]   lsu_state;
   logic [PCB*T-1:0] next_pc;
   logic [2:0]       core_state;
   logic [PCB-1:0]   current_pc;
   logic [T-1:0]     thread_mask;
   logic             done;
`ifdef DIVERGENCE_STATS_EN
   logic [15:0]      divergence_count;
`endif

   divergent_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(PCB)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .start                    (start),
      .thread_count             (thread_count),
      .fetcher_state            (fetcher_state),
      .decoded_mem_read_enable  (rd_en),
      .decoded_mem_write_enable (wr_en),
      .decoded_ret              (ret_en),
      .lsu_state                (lsu_state),
      .next_pc                  (next_pc),
      .core_state               (core_state),
      .current_pc               (current_pc),
      .thread_mask              (thread_mask),
      .done                     (done)
`ifdef DIVERGENCE_STATS_EN
      ,
      .divergence_count         (divergence_count)
`endif
   );

   always #5 clk = ~clk;

   // Program memory: opcode, per-lane branch target and per-lane memory latency.
   int op  [NPC];
   int tgt [NPC][T];
   int wl  [NPC][T];

   typedef struct { int pc; int mask; int wt; } exp_t;
   exp_t exp_q[$];
   int   exp_div;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit legal(input logic [2:0] a, input logic [2:0] b);
      case (a)
         3'd0:    return (b == 3'd1) || (b == 3'd7);
         3'd1:    return b == 3'd2;
         3'd2:    return b == 3'd3;
         3'd3:    return b == 3'd4;
         3'd4:    return b == 3'd5;
         3'd5:    return b == 3'd6;
         3'd6:    return (b == 3'd1) || (b == 3'd7);
         default: return 1'b0;
      endcase
   endfunction

   // Reference model: walk the program at lane granularity, always running the
   // group of unretired lanes sitting at the smallest PC.
   task automatic build_expect(input int tcs);
      int pcs[T];
      bit rt[T];
      bit first;
      int mn, mask, alive, mx;
      exp_t e;
      exp_q.delete();
      exp_div = 0;
      first   = 1'b1;
      for (int i = 0; i < T; i++) begin
         pcs[i] = 0;
         rt[i]  = (i >= tcs);
      end
      for (int guard = 0; guard < 2000; guard++) begin
         mn = 1 << 30; mask = 0; alive = 0;
         for (int i = 0; i < T; i++) if (!rt[i] && pcs[i] < mn) mn = pcs[i];
         if (mn == (1 << 30)) break;
         for (int i = 0; i < T; i++) begin
            if (!rt[i]) alive |= (1 << i);
            if (!rt[i] && pcs[i] == mn) mask |= (1 << i);
         end
         if (!first && mask != alive) exp_div++;
         first = 1'b0;
         e.pc = mn; e.mask = mask; e.wt = 1;
         if (op[mn] == OP_LDR || op[mn] == OP_STR) begin
            mx = 0;
            for (int i = 0; i < T; i++) if (mask[i] && wl[mn][i] > mx) mx = wl[mn][i];
            e.wt = mx + 1;
         end
         exp_q.push_back(e);
         for (int i = 0; i < T; i++) begin
            if (mask[i]) begin
               if (op[mn] == OP_RET) rt[i] = 1'b1;
               else                  pcs[i] = tgt[mn][i];
            end
         end
      end
   endtask

   task automatic setup_prog(input int kind);
      for (int p = 0; p < NPC; p++) begin
         op[p] = OP_RET;
         for (int i = 0; i < T; i++) begin
            tgt[p][i] = (p + 1 < NPC) ? p + 1 : NPC - 1;
            wl[p][i]  = 0;
         end
      end
      case (kind)
         0: for (int p = 0; p < 4; p++) op[p] = OP_ALU;
         1: begin
            for (int p = 0; p < 7; p++) op[p] = OP_ALU;
            tgt[2][0] = 3; tgt[2][1] = 3; tgt[2][2] = 7; tgt[2][3] = 7;
         end
         2: begin
            op[0] = OP_LDR; wl[0][2] = 4;
            op[1] = OP_STR;
            for (int i = 0; i < T; i++) wl[1][i] = int'($urandom_range(0, 3));
         end
         3: begin
            op[0] = OP_ALU;
            tgt[0][0] = 5; tgt[0][1] = 5; tgt[0][2] = 9; tgt[0][3] = 9;
         end
         4: begin
            op[0] = OP_LDR;
            for (int i = 0; i < T; i++) wl[0][i] = 30;
         end
         default: begin
            for (int p = 0; p < NPC - 1; p++) begin
               int r;
               r = int'($urandom_range(0, 11));
               op[p] = (r == 0 && p > 2) ? OP_RET : (r <= 2) ? OP_LDR : (r == 3) ? OP_STR : OP_ALU;
               if ($urandom_range(0, 3) == 0) begin
                  for (int i = 0; i < T; i++) begin
                     tgt[p][i] = p + int'($urandom_range(1, 6));
                     if (tgt[p][i] > NPC - 1) tgt[p][i] = NPC - 1;
                  end
               end
               for (int i = 0; i < T; i++) wl[p][i] = int'($urandom_range(0, 3));
            end
         end
      endcase
   endtask

   // Environment: fetcher, decoder, pc units and LSUs reacting to the issued PC.
   int fetch_cnt = 0;
   int wait_cnt  = 0;
   initial begin
      int pcv;
      bit memop;
      fetcher_state = 3'd0; rd_en = 1'b0; wr_en = 1'b0; ret_en = 1'b0;
      lsu_state = '0; next_pc = '0;
      forever begin
         @(negedge clk);
         pcv = int'(current_pc);
         if (pcv >= NPC) pcv = NPC - 1;
         if (core_state == 3'd1) begin
            fetcher_state = (fetch_cnt >= 1) ? FETCHER_FETCHED : 3'b001;
            fetch_cnt++;
         end else begin
            fetcher_state = 3'b000;
            fetch_cnt = 0;
         end
         memop  = (op[pcv] == OP_LDR) || (op[pcv] == OP_STR);
         rd_en  = (op[pcv] == OP_LDR);
         wr_en  = (op[pcv] == OP_STR);
         ret_en = (op[pcv] == OP_RET);
         for (int i = 0; i < T; i++) begin
            next_pc[PCB*i +: PCB] = PCB'(tgt[pcv][i]);
            if (!thread_mask[i])
               lsu_state[2*i +: 2] = ($urandom_range(0, 1) == 1) ? LSU_WAITING : LSU_REQUESTING;
            else if (core_state == 3'd4 && memop)
               lsu_state[2*i +: 2] = (wait_cnt < wl[pcv][i]) ?
                                     ((wait_cnt == 0) ? LSU_REQUESTING : LSU_WAITING) : LSU_DONE;
            else
               lsu_state[2*i +: 2] = LSU_IDLE;
         end
         if (core_state == 3'd4) wait_cnt++;
         else                    wait_cnt = 0;
      end
   end

   // Monitor: pops the model's issue list as the DUT enters FETCH.
   initial begin
      logic [2:0] prev, st;
      int dur, cur_wait;
      exp_t cur;
      prev = 3'd0; dur = 0; cur_wait = 1;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = 3'd0; dur = 0;
         end else begin
            st = core_state;
            if (st != prev) begin
               case (prev)
                  3'd1:                   chk("fetch_len", dur, 2);
                  3'd2, 3'd3, 3'd5, 3'd6: chk("stage_len", dur, 1);
                  3'd4:                   chk("wait_len", dur, cur_wait);
                  default: ;
               endcase
               chk("transition", {29'd0, prev} * 8 + int'(st),
                   legal(prev, st) ? {29'd0, prev} * 8 + int'(st) : -1);
               if (st == 3'd1) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_issue", int'(current_pc), -1);
                  end else begin
                     cur = exp_q.pop_front();
                     chk("issue_pc", int'(current_pc), cur.pc);
                     chk("issue_mask", int'(thread_mask), cur.mask);
                     cur_wait = cur.wt;
                  end
               end
               if (st == 3'd7) begin
                  chk("pending_issues", exp_q.size(), 0);
                  chk("done_flag", int'(done), 1);
                  chk("done_mask", int'(thread_mask), 0);
`ifdef DIVERGENCE_STATS_EN
                  chk("div_count", int'(divergence_count), exp_div);
`endif
               end else begin
                  chk("done_low", int'(done), 0);
               end
               dur = 1;
            end else begin
               dur++;
            end
            prev = st;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_state", int'(core_state), 0);
      chk("rst_mask", int'(thread_mask), 0);
      chk("rst_pc", int'(current_pc), 0);
      chk("rst_done", int'(done), 0);
   endtask

   task automatic kick(input int tc);
      int tcs;
      tcs = (tc > T) ? T : tc;
      build_expect(tcs);
      @(posedge clk); #1;
      start = 1'b1; thread_count = TCW'(tc);
      @(posedge clk); #1;
      start = 1'b0;
      chk("launch_state", int'(core_state), (tcs == 0) ? 7 : 1);
      chk("launch_mask", int'(thread_mask), (1 << tcs) - 1);
      chk("launch_pc", int'(current_pc), 0);
   endtask

   task automatic finish_block();
      int n;
      for (n = 0; n < 5000; n++) begin
         if (done) break;
         @(posedge clk); #1;
      end
      chk("done_timeout", int'(done), 1);
      start = 1'b1; thread_count = TCW'(T);
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("done_hold_state", int'(core_state), 7);
      chk("done_hold_flag", int'(done), 1);
   endtask

   task automatic run_block(input int kind, input int tc);
      do_reset();
      setup_prog(kind);
      kick(tc);
      finish_block();
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; thread_count = '0;
      setup_prog(0);
      #1;
      chk("por_state", int'(core_state), 0);
      chk("por_done", int'(done), 0);

      run_block(0, 4);
      run_block(1, 4);
      run_block(2, 3);
      run_block(2, 4);
      run_block(3, 4);
      run_block(0, 0);
      run_block(0, 7);

      // Asynchronous reset while the block sits in a long memory wait.
      do_reset();
      setup_prog(4);
      kick(4);
      for (n = 0; n < 200; n++) begin
         if (core_state == 3'd4) break;
         @(posedge clk); #1;
      end
      chk("reach_wait", int'(core_state), 4);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("async_rst_state", int'(core_state), 0);
      chk("async_rst_mask", int'(thread_mask), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_pc", int'(current_pc), 0);
      exp_q.delete();
      @(posedge clk); #1 reset = 1'b0;
      setup_prog(0);
      kick(4);
      finish_block();

      for (int b = 0; b < 25; b++) run_block(9, int'($urandom_range(0, 7)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
